// File: rtl/top.sv
// rtl/top.sv - SPI flash JEDEC-ID reader driving a multiplexed active-low 8x4 LED matrix.
// Define SPI_REREAD_EN to repeat the ID read every 2^20 clk cycles after completion.
module top #(
    parameter int         SCK_DIV  = 2,
    parameter int         SCAN_DIV = 12000,
    parameter logic [7:0] CMD      = 8'h9F
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] led,
    output logic [3:0] col,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_READ, S_END, S_DONE} state_t;

    localparam int             DW        = $clog2(SCK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(SCK_DIV - 1);
    localparam int             SW        = $clog2(SCAN_DIV + 1);
    localparam logic [SW-1:0]  SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t        state_q;
    logic          cs_q, sck_q, mosi_q, done_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_q;
    logic [23:0]   sh_q;
    logic [7:0]    id0_q, id1_q, id2_q;
`ifdef SPI_REREAD_EN
    logic [19:0]   rr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            id0_q   <= '0;
            id1_q   <= '0;
            id2_q   <= '0;
            done_q  <= 1'b0;
`ifdef SPI_REREAD_EN
            rr_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cs_q    <= 1'b0;
                    sck_q   <= 1'b0;
                    mosi_q  <= CMD[7];
                    div_q   <= '0;
                    bit_q   <= '0;
                    state_q <= S_CMD;
                end
                S_CMD, S_READ: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            // rising SCK edge: flash data is stable here
                            if (state_q == S_READ) sh_q <= {sh_q[22:0], miso};
                        end else if (state_q == S_CMD) begin
                            if (bit_q == 5'd7) begin
                                mosi_q  <= 1'b0;
                                bit_q   <= '0;
                                state_q <= S_READ;
                            end else begin
                                mosi_q <= CMD[3'd6 - bit_q[2:0]];
                                bit_q  <= bit_q + 5'd1;
                            end
                        end else if (bit_q == 5'd23) begin
                            bit_q   <= '0;
                            state_q <= S_END;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_END: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        cs_q    <= 1'b1;
                        id0_q   <= sh_q[23:16];
                        id1_q   <= sh_q[15:8];
                        id2_q   <= sh_q[7:0];
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_DONE: begin
                    cs_q   <= 1'b1;
                    sck_q  <= 1'b0;
                    mosi_q <= 1'b0;
`ifdef SPI_REREAD_EN
                    rr_q <= rr_q + 1'b1;
                    if (rr_q == '1) state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [SW-1:0] scan_q;
    logic [1:0]    idx_q;
    logic [3:0]    col_q;
    logic [7:0]    led_q;
    logic [7:0]    led_d;
    logic          id_valid;

    assign id_valid = done_q && (id0_q != 8'h00) && (id0_q != 8'hFF);

    always_comb begin
        led_d = 8'hFF;
        case (idx_q)
            2'd0:    led_d = ~id0_q;
            2'd1:    led_d = ~id1_q;
            2'd2:    led_d = ~id2_q;
            default: led_d = ~{6'b0, id_valid, done_q};
        endcase
    end

    // col and led are registered from the same index so they always change together
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
            col_q  <= 4'b1111;
            led_q  <= 8'hFF;
        end else begin
            if (scan_q == SCAN_LAST) begin
                scan_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            col_q <= ~(4'b0001 << idx_q);
            led_q <= led_d;
        end
    end

    assign cs   = cs_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign col  = col_q;
    assign led  = led_q;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - randomized self-checking bench for the SPI JEDEC-ID reader and LED scan.
module tb_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       miso = 1'b0;
    logic [7:0] led;
    logic [3:0] col;
    logic       cs, sck, mosi;

    top #(.SCK_DIV(2), .SCAN_DIV(4), .CMD(8'h9F)) dut (
        .clk(clk), .rst(rst), .led(led), .col(col),
        .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flash model: shifts the 24-bit ID out on SCK falling edges after the command byte
    logic [23:0] flash_val = 24'h0;
    logic [7:0]  mosi_byte = 8'h0;
    int          rise_cnt = 0, fall_cnt = 0, cyc = 0, t0 = 0, t1 = 0;
    logic        sck_prev = 1'b0, cs_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (cs_prev && !cs) begin
            rise_cnt  = 0;
            fall_cnt  = 0;
            mosi_byte = 8'h0;
        end
        if (!cs && sck && !sck_prev) begin
            if (rise_cnt < 8) mosi_byte = {mosi_byte[6:0], mosi};
            if (rise_cnt == 0) t0 = cyc;
            if (rise_cnt == 1) t1 = cyc;
            rise_cnt++;
        end
        if (!cs && !sck && sck_prev) begin
            fall_cnt++;
            if (fall_cnt >= 8 && fall_cnt < 32) miso = flash_val[31 - fall_cnt];
        end
        sck_prev = sck;
        cs_prev  = cs;
    end

    function automatic logic [7:0] exp_led(input int c, input logic [23:0] v);
        logic [7:0] m;
        m = v[23:16];
        case (c)
            0:       return ~m;
            1:       return ~v[15:8];
            2:       return ~v[7:0];
            default: return ~{6'b0, (m != 8'h00 && m != 8'hFF), 1'b1};
        endcase
    endfunction

    function automatic int col_index(input logic [3:0] c);
        case (c)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic reset_and_release(input logic [23:0] v);
        flash_val = v;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cs", cs, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_led", led, 8'hFF);
        check("rst_col", col, 4'b1111);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cs_fall", cs, 1'b0);
        check("first_mosi", mosi, 1'b1);
    endtask

    task automatic run_txn(input logic [23:0] v);
        int n, run, changes, pci, ci;
        logic [3:0] pc;
        reset_and_release(v);
        n = 0;
        while (cs !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("txn_done", (n < 1000), 1);
        check("cmd_byte", mosi_byte, 8'h9F);
        check("sck_rises", rise_cnt, 32);
        check("sck_period", t1 - t0, 4);
        repeat (2) @(negedge clk);
        run = 0;
        changes = 0;
        pc = col;
        pci = col_index(col);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ci = col_index(col);
            check("col_onehot", (ci >= 0), 1);
            if (ci >= 0) check("led_data", led, exp_led(ci, v));
            if (col == pc) begin
                run++;
            end else begin
                if (changes > 0) check("col_period", run, 4);
                check("col_order", ci, (pci + 1) % 4);
                changes++;
                run = 1;
                pc = col;
                pci = ci;
            end
        end
        check("done_cs", cs, 1'b1);
        check("done_sck", sck, 1'b0);
        check("done_mosi", mosi, 1'b0);
    endtask

    task automatic abort_txn(input logic [23:0] v);
        int n;
        reset_and_release(v);
        n = 0;
        while (rise_cnt != 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_read", (n < 1000), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", cs, 1'b1);
        check("abort_sck", sck, 1'b0);
    endtask

    initial begin
        run_txn(24'h1F8501);
        run_txn(24'hFFFFFF);
        run_txn(24'h000000);
        for (int k = 0; k < 4; k++) run_txn(24'($urandom));
        abort_txn(24'($urandom));
        run_txn(24'($urandom));
        abort_txn(24'hA5C33C);
        run_txn(24'h1F8501);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Top-level SPI flash JEDEC-ID reader for a board with an 8x4 LED matrix.
- After reset it runs one SPI mode-0 transaction: command 0x9F, then three ID bytes read back.
- The three bytes (manufacturer, device ID 1, device ID 2) are latched and shown on a multiplexed, active-low LED matrix.

Parameters:
- SCK_DIV, 2, clk cycles per SCK half-period (≥1).
- SCAN_DIV, 12000, clk cycles each matrix column stays active.
- CMD, 8'h9F, SPI command byte sent MSB first.

Ports:
- clk  in  1  system clock (12 MHz on board).
- rst  in  1  synchronous reset, active-high.
- led  out  8  LED row data, active-low (0 = lit).
- col  out  4  column select, active-low one-hot.
- cs  out  1  flash chip select, active-low.
- sck  out  1  SPI clock, idles low.
- mosi  out  1  SPI data to flash.
- miso  in  1  SPI data from flash.

Behaviour:
- Reset (sampled on posedge clk while rst=1) drives these values:
  - cs=1, sck=0, mosi=0, led=8'hFF, col=4'b1111.
  - FSM in IDLE; id bytes cleared to 0; done=0; divider and bit counters cleared.
- Reset asserted mid-transaction aborts it on the next edge: cs=1, sck=0. Release restarts from IDLE.
- FSM states: IDLE -> CMD -> READ -> END -> DONE.
- IDLE: one cycle after rst deasserts. Then cs<=0, mosi<=CMD[7], sck=0, go to CMD.
- SCK generation: a half-period counter toggles sck every SCK_DIV clk cycles while in CMD/READ.
  - One SCK period = 2*SCK_DIV clk cycles.
- CMD: 8 SCK periods.
  - mosi updates only when sck falls (or on CS assert for bit 7).
  - Bits go out MSB first; mosi is stable at every rising edge.
  - After the 8th falling edge: mosi<=0, go to READ.
- READ: 24 SCK periods.
  - miso is sampled on the clk edge that drives sck 0->1.
  - It shifts into a 24-bit shift register MSB first: byte0 = first 8 bits, byte1 = next, byte2 = last.
- END: after the 24th falling edge, hold sck=0 for SCK_DIV cycles, then cs<=1.
  - The shift register is copied to id0/id1/id2 and done<=1. Go to DONE.
- DONE: cs=1, sck=0, mosi=0 permanently (unless reset or the optional feature applies).
- Display scan:
  - A scan counter advances the active column every SCAN_DIV cycles: col sequence 1110 -> 1101 -> 1011 -> 0111 -> wrap.
  - Exactly one col bit is low at any time after reset.
  - Column 0 shows ~id0, column 1 ~id1, column 2 ~id2.
  - Column 3 shows status ~{6'b0, id_valid, done}.
    - id_valid = done && id0 != 8'h00 && id0 != 8'hFF.
  - While done=0: led=8'hFF for columns 0-2; column 3 shows the status pattern (led=8'hFF).
- Edge cases:
  - miso stuck low gives ids 00 with id_valid=0.
  - miso stuck high gives ids FF with id_valid=0.
  - Outputs are registered; no combinational path from miso to any output.

Optional Feature:
- Macro SPI_REREAD_EN.
- Defined:
  - In DONE, count 2^20 clk cycles, then return to IDLE and repeat the transaction.
  - id0-id2 keep old values until the new transaction's END, so the display never shows partial data.
  - done stays 1 after the first completion.
- Not defined: single transaction per reset; DONE is terminal.

Test Plan:
- Reset held 5 cycles -> cs=1, sck=0, mosi=0, led=FF, col=1111. Release -> cs falls 1 cycle later.
- Command check, SCK_DIV=2: capture mosi on 8 sck rising edges -> 1001_1111 (0x9F). sck period = 4 clk cycles.
- miso drives 0x1F, 0x85, 0x01 aligned to sck rising edges -> id0=1F, id1=85, id2=01, done=1, cs returns high; 32 sck rising edges total.
- Display, SCAN_DIV=4, after the previous read:
  - col=1110 -> led=E0; col=1101 -> led=7A; col=1011 -> led=FE; col=0111 -> led=FC.
  - Columns step every 4 cycles.
- miso tied 1 -> ids FF, column 3 led=FE (done=1, id_valid=0).
- rst pulsed during READ -> cs=1, sck=0 next cycle; the restarted transaction resends 0x9F; ids captured from the new transaction only.
